// File: rtl/spi_word_initiator.sv
// SPI mode-0 initiator: shifts one WORD_BITS word per start request, MSB first,
// and captures the responder's word from CIPO within the same frame.
module spi_word_initiator #(
  parameter int unsigned WORD_BITS   = 64,
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned CS_SETUP    = 2,
  parameter int unsigned CS_HOLD     = 2,
  parameter int unsigned CS_GAP      = 4
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WORD_BITS-1:0] tx_word,
  input  logic                 hold_cs,
  input  logic                 release_cs,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_BITS-1:0] rx_word,
  output logic                 SCK,
  output logic                 CS,
  output logic                 COPI,
  input  logic                 CIPO
);

  localparam int unsigned BW    = $clog2(WORD_BITS + 1);
  localparam int unsigned MAX_A = (HALF_PERIOD > CS_SETUP) ? HALF_PERIOD : CS_SETUP;
  localparam int unsigned MAX_B = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int unsigned MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW    = $clog2(MAX_D) + 1;

  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(WORD_BITS - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, GAP} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [WORD_BITS-1:0]   tx_q, tx_d;
  logic [WORD_BITS-1:0]   rx_sh_q, rx_sh_d;
  logic [WORD_BITS-1:0]   rx_word_q, rx_word_d;
  logic                   hold_q, hold_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   sck_q, sck_d;
  logic                   cs_q, cs_d;
  logic                   copi_q, copi_d;

  always_comb begin
    // NOTE: every next-state signal gets a default here so no path leaves one
    // unassigned; that is what keeps this block from inferring latches.
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_word_d = rx_word_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sck_d     = sck_q;
    cs_d      = cs_q;
    copi_d    = copi_q;

    unique case (state_q)
      IDLE: begin
        // start outranks release_cs, so a chained word keeps CS asserted
        if (start) begin
          tx_d    = tx_word;
          hold_d  = hold_cs;
          cs_d    = 1'b0;
          copi_d  = tx_word[WORD_BITS-1];
          busy_d  = 1'b1;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = SETUP;
        end else if (!cs_q && release_cs) begin
          cs_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = SHIFT_LO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT_LO: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          sck_d   = 1'b1;
          state_d = SHIFT_HI;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (cnt_q == HALF_LAST) begin
          // CIPO is sampled just before SCK falls, when the responder's bit is settled
          cnt_d   = '0;
          sck_d   = 1'b0;
          rx_sh_d = {rx_sh_q[WORD_BITS-2:0], CIPO};
          if (bit_q == BIT_LAST) begin
            copi_d  = 1'b0;
            state_d = HOLD;
          end else begin
            bit_d   = bit_q + 1'b1;
            copi_d  = tx_q[WORD_BITS-2];
            tx_d    = tx_q << 1;
            state_d = SHIFT_LO;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d     = '0;
          rx_word_d = rx_sh_q;
          done_d    = 1'b1;
          if (hold_q) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            cs_d    = 1'b1;
            state_d = GAP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_sh_q   <= '0;
      rx_word_q <= '0;
      hold_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
      copi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      rx_word_q <= rx_word_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sck_q     <= sck_d;
      cs_q      <= cs_d;
      copi_q    <= copi_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_word = rx_word_q;
  assign SCK     = sck_q;
  assign CS      = cs_q;
  assign COPI    = copi_q;

endmodule

// File: tb/tb_spi_word_initiator.sv
// Bench for spi_word_initiator: a mode-0 responder model supplies CIPO words and
// records COPI words; each test task checks frames against that model.
module tb_spi_word_initiator;

  localparam int W     = 64;
  localparam int HP    = 4;
  localparam int SETUP = 2;
  localparam int HOLDC = 2;
  localparam int GAPC  = 4;
  localparam int LAT   = SETUP + 2 * HP * W + HOLDC;
  localparam logic [7:0] VER_MAJ   = 8'd1;
  localparam logic [7:0] VER_MIN   = 8'd4;
  localparam logic [7:0] VER_PATCH = 8'd2;

  logic         CLK = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         hold_cs = 1'b0;
  logic         release_cs = 1'b0;
  logic         CIPO = 1'b0;
  logic [W-1:0] tx_word = '0;
  logic         busy, done, SCK, CS, COPI;
  logic [W-1:0] rx_word;

  int tests_run = 0;
  int tests_failed = 0;

  spi_word_initiator #(
    .WORD_BITS(W), .HALF_PERIOD(HP), .CS_SETUP(SETUP), .CS_HOLD(HOLDC), .CS_GAP(GAPC)
  ) dut (
    .CLK(CLK), .reset(reset), .start(start), .tx_word(tx_word), .hold_cs(hold_cs),
    .release_cs(release_cs), .busy(busy), .done(done), .rx_word(rx_word),
    .SCK(SCK), .CS(CS), .COPI(COPI), .CIPO(CIPO)
  );

  always #5 CLK = ~CLK;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Responder model: presents queued words MSB first on CIPO, records COPI words
  logic [W-1:0] resp_q[$];
  logic [W-1:0] copi_seen[$];
  logic [W-1:0] cur_word = '0;
  logic [W-1:0] copi_word = '0;
  int pos = 0;
  bit loaded = 0, from_q = 0, word_end = 0, resp_auto = 0;
  int sck_rises = 0, sck_bad = 0;

  task automatic load_next();
    if (resp_q.size() > 0) begin
      cur_word = resp_q.pop_front();
      from_q = 1;
    end else begin
      cur_word = '0;
      from_q = 0;
    end
    loaded = 1;
  endtask

  always @(negedge CS) begin
    if (!loaded) load_next();
    pos = 0;
    CIPO = cur_word[W-1];
  end

  always @(posedge CS) begin
    if (loaded && pos == 0 && from_q) resp_q.push_front(cur_word);
    loaded = 0;
    pos = 0;
    word_end = 0;
  end

  always @(posedge SCK) begin
    sck_rises++;
    if (CS) sck_bad++;
    copi_word = {copi_word[W-2:0], COPI};
    pos++;
    if (pos == W) begin
      copi_seen.push_back(copi_word);
      pos = 0;
      word_end = 1;
      loaded = 0;
      if (resp_auto && copi_word[W-1 -: 8] == 8'hFE)
        resp_q.push_front({40'h0, VER_MAJ, VER_MIN, VER_PATCH});
    end
  end

  always @(negedge SCK) begin
    if (word_end) begin
      word_end = 0;
      load_next();
    end
    if (loaded) CIPO = cur_word[W-1-pos];
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic launch(input logic [W-1:0] w, input logic h);
    tx_word = w;
    hold_cs = h;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    hold_cs = 1'b0;
    tx_word = {$urandom, $urandom};
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < LAT + 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    tests_run++; if (CS !== 1'b1) begin tests_failed++; $display("FAIL reset_cs: got %b want 1", CS); end
    tests_run++; if (SCK !== 1'b0) begin tests_failed++; $display("FAIL reset_sck: got %b want 0", SCK); end
    tests_run++; if (COPI !== 1'b0) begin tests_failed++; $display("FAIL reset_copi: got %b want 0", COPI); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
    tests_run++; if (rx_word !== '0) begin tests_failed++; $display("FAIL reset_rx: got %h want 0", rx_word); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_word();
    logic [W-1:0] tx = 64'h0100_0000_0000_0001;
    logic [W-1:0] rsp = 64'hDEAD_BEEF_0123_4567;
    int n, g, pulses, cs_lo, r0;
    resp_q.delete(); copi_seen.delete(); sck_bad = 0; r0 = sck_rises;
    resp_q.push_back(rsp);
    launch(tx, 1'b0);
    tests_run++; if (CS !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL single_accept: cs=%b busy=%b want cs=0 busy=1", CS, busy); end
    wait_done(n);
    tests_run++; if (n != LAT) begin tests_failed++; $display("FAIL single_latency: got %0d want %0d", n, LAT); end
    tests_run++; if (rx_word !== rsp) begin tests_failed++; $display("FAIL single_rx: got %h want %h", rx_word, rsp); end
    tests_run++; if (sck_rises - r0 != W) begin tests_failed++; $display("FAIL single_sck_rises: got %0d want %0d", sck_rises - r0, W); end
    tests_run++; if (copi_seen.size() != 1 || copi_seen[0] !== tx) begin tests_failed++; $display("FAIL single_copi: got %0d words first %h want %h", copi_seen.size(), copi_seen.size() > 0 ? copi_seen[0] : '0, tx); end
    g = 0; pulses = 0; cs_lo = 0;
    while (busy === 1'b1 && g < 20) begin
      if (done === 1'b1) pulses++;
      if (CS !== 1'b1) cs_lo++;
      g++;
      tick();
    end
    tests_run++; if (g != GAPC || cs_lo != 0) begin tests_failed++; $display("FAIL single_gap: got %0d busy cycles with cs_low=%0d want %0d with 0", g, cs_lo, GAPC); end
    tests_run++; if (pulses != 1) begin tests_failed++; $display("FAIL single_done_pulse: got %0d cycles want 1", pulses); end
    tests_run++; if (rx_word !== rsp || sck_bad != 0) begin tests_failed++; $display("FAIL single_rx_hold: got %h sck_bad=%0d want %h 0", rx_word, sck_bad, rsp); end
  endtask

  task automatic test_message();
    logic [W-1:0] tx[3];
    logic [W-1:0] rsp[3];
    int n, g, cs_hi, r0;
    resp_q.delete(); copi_seen.delete(); sck_bad = 0; r0 = sck_rises; cs_hi = 0;
    for (int i = 0; i < 3; i++) begin
      tx[i]  = {$urandom, $urandom};
      rsp[i] = {$urandom, $urandom};
      resp_q.push_back(rsp[i]);
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 1) release_cs = 1'b1;
      launch(tx[i], 1'b1);
      release_cs = 1'b0;
      if (CS !== 1'b0) cs_hi++;
      wait_done(n);
      tests_run++; if (n != LAT || rx_word !== rsp[i]) begin tests_failed++; $display("FAIL msg_word%0d: latency %0d rx %h want %0d %h", i, n, rx_word, LAT, rsp[i]); end
      tests_run++; if (busy !== 1'b0 || CS !== 1'b0) begin tests_failed++; $display("FAIL msg_held%0d: busy=%b cs=%b want 0 0", i, busy, CS); end
    end
    repeat (3) begin
      tick();
      if (CS !== 1'b0) cs_hi++;
    end
    tests_run++; if (cs_hi != 0) begin tests_failed++; $display("FAIL msg_cs_low: got %0d high samples want 0", cs_hi); end
    tests_run++; if (sck_rises - r0 != 3 * W) begin tests_failed++; $display("FAIL msg_sck_rises: got %0d want %0d", sck_rises - r0, 3 * W); end
    for (int i = 0; i < 3; i++) begin
      tests_run++; if (copi_seen.size() <= i || copi_seen[i] !== tx[i]) begin tests_failed++; $display("FAIL msg_copi%0d: got %h want %h", i, copi_seen.size() > i ? copi_seen[i] : '0, tx[i]); end
    end
    release_cs = 1'b1;
    tick();
    release_cs = 1'b0;
    tests_run++; if (CS !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("FAIL msg_release: cs=%b busy=%b want 1 1", CS, busy); end
    g = 0;
    while (busy === 1'b1 && g < 20) begin g++; tick(); end
    tests_run++; if (g != GAPC || sck_bad != 0) begin tests_failed++; $display("FAIL msg_gap: got %0d sck_bad=%0d want %0d 0", g, sck_bad, GAPC); end
  endtask

  task automatic test_ignored_start();
    logic [W-1:0] tx  = {$urandom, $urandom};
    logic [W-1:0] rsp = {$urandom, $urandom};
    int n, g, pulses, r0, r1, bad;
    resp_q.delete(); copi_seen.delete(); r0 = sck_rises;
    resp_q.push_back(rsp);
    launch(tx, 1'b0);
    repeat (100) tick();
    tx_word = ~tx; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    tests_run++; if (n + 101 != LAT) begin tests_failed++; $display("FAIL ign_latency: got %0d want %0d", n + 101, LAT); end
    tests_run++; if (rx_word !== rsp || copi_seen.size() != 1 || copi_seen[0] !== tx) begin tests_failed++; $display("FAIL ign_frame: rx %h words %0d want %h 1", rx_word, copi_seen.size(), rsp); end
    start = 1'b1;
    tick();
    start = 1'b0;
    g = 1; pulses = 0;
    while (busy === 1'b1 && g < 20) begin g++; tick(); end
    tests_run++; if (g != GAPC) begin tests_failed++; $display("FAIL ign_gap: got %0d want %0d", g, GAPC); end
    r1 = sck_rises; bad = 0;
    repeat (20) begin
      if (done === 1'b1) pulses++;
      if (CS !== 1'b1 || busy !== 1'b0) bad++;
      tick();
    end
    tests_run++; if (pulses != 0 || bad != 0 || sck_rises != r1 || sck_rises - r0 != W) begin tests_failed++; $display("FAIL ign_no_frame: done=%0d bad=%0d rises=%0d want 0 0 %0d", pulses, bad, sck_rises - r0, W); end
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] tx2  = {$urandom, $urandom};
    logic [W-1:0] rsp2 = {$urandom, $urandom};
    int n, r0, pulses, bad;
    resp_q.delete(); copi_seen.delete(); r0 = sck_rises; n = 0;
    resp_q.push_back({$urandom, $urandom});
    launch({$urandom, $urandom}, 1'b0);
    while (sck_rises - r0 < 30 && n < LAT) begin tick(); n++; end
    tests_run++; if (sck_rises - r0 != 30) begin tests_failed++; $display("FAIL rst_reach_bit30: got %0d rises want 30", sck_rises - r0); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++; if (CS !== 1'b1 || SCK !== 1'b0 || COPI !== 1'b0) begin tests_failed++; $display("FAIL rst_pins: cs=%b sck=%b copi=%b want 1 0 0", CS, SCK, COPI); end
    tests_run++; if (busy !== 1'b0 || done !== 1'b0 || rx_word !== '0) begin tests_failed++; $display("FAIL rst_state: busy=%b done=%b rx=%h want 0 0 0", busy, done, rx_word); end
    r0 = sck_rises; pulses = 0; bad = 0;
    repeat (LAT + 20) begin
      if (done === 1'b1) pulses++;
      if (CS !== 1'b1) bad++;
      tick();
    end
    tests_run++; if (pulses != 0 || bad != 0 || sck_rises != r0) begin tests_failed++; $display("FAIL rst_quiet: done=%0d cs_low=%0d rises=%0d want 0 0 0", pulses, bad, sck_rises - r0); end
    resp_q.delete(); copi_seen.delete();
    resp_q.push_back(rsp2);
    launch(tx2, 1'b0);
    wait_done(n);
    tests_run++; if (n != LAT || rx_word !== rsp2) begin tests_failed++; $display("FAIL rst_restart: latency %0d rx %h want %0d %h", n, rx_word, LAT, rsp2); end
    tests_run++; if (copi_seen.size() != 1 || copi_seen[0] !== tx2 || sck_rises - r0 != W) begin tests_failed++; $display("FAIL rst_restart_copi: words %0d rises %0d want 1 %0d", copi_seen.size(), sck_rises - r0, W); end
    n = 0;
    while (busy === 1'b1 && n < 20) begin n++; tick(); end
  endtask

  task automatic test_version();
    logic [W-1:0] ver = {40'h0, VER_MAJ, VER_MIN, VER_PATCH};
    int n;
    resp_q.delete(); copi_seen.delete(); resp_auto = 1;
    launch(64'hFE00_0000_0000_0000, 1'b1);
    wait_done(n);
    launch('0, 1'b0);
    wait_done(n);
    tests_run++; if (rx_word[23:0] !== ver[23:0]) begin tests_failed++; $display("FAIL version_field: got %h want %h", rx_word[23:0], ver[23:0]); end
    tests_run++; if (n != LAT || rx_word !== ver) begin tests_failed++; $display("FAIL version_word: latency %0d rx %h want %0d %h", n, rx_word, LAT, ver); end
    n = 0;
    while (busy === 1'b1 && n < 20) begin n++; tick(); end
    resp_auto = 0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_message();
    test_ignored_start();
    test_reset_mid_frame();
    test_version();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
